// File: rtl/mips_ir_pkg.sv
// MIPS instruction field positions, widths and the nop encoding.
// Shared by the instruction register and later decode stages.
package mips_ir_pkg;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int ADDR_MSB  = 25;

    localparam int OP_W    = OP_MSB - OP_LSB + 1;
    localparam int REG_W   = RS_MSB - RS_LSB + 1;
    localparam int SHAMT_W = SHAMT_MSB - SHAMT_LSB + 1;
    localparam int FUNCT_W = FUNCT_MSB - FUNCT_LSB + 1;
    localparam int IMM_W   = IMM_MSB + 1;
    localparam int ADDR_W  = ADDR_MSB + 1;

    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/ir_field_decode.sv
// Purely combinational split of a 32-bit MIPS word into its fields.
// Used by the instruction register and reusable by other stages.
module ir_field_decode
    import mips_ir_pkg::*;
(
    input  logic [31:0]        instr_i,
    output logic [OP_W-1:0]    opcode_o,
    output logic [REG_W-1:0]   rs_o,
    output logic [REG_W-1:0]   rt_o,
    output logic [REG_W-1:0]   rd_o,
    output logic [SHAMT_W-1:0] shamt_o,
    output logic [FUNCT_W-1:0] funct_o,
    output logic [IMM_W-1:0]   imm16_o,
    output logic [ADDR_W-1:0]  addr26_o
);

    // Fixed bit slices; no logic beyond wiring.
    always_comb begin
        opcode_o = instr_i[OP_MSB:OP_LSB];
        rs_o     = instr_i[RS_MSB:RS_LSB];
        rt_o     = instr_i[RT_MSB:RT_LSB];
        rd_o     = instr_i[RD_MSB:RD_LSB];
        shamt_o  = instr_i[SHAMT_MSB:SHAMT_LSB];
        funct_o  = instr_i[FUNCT_MSB:FUNCT_LSB];
        imm16_o  = instr_i[IMM_MSB:0];
        addr26_o = instr_i[ADDR_MSB:0];
    end

endmodule

// File: rtl/ir_queue.sv
// Instruction register with a small circular prefetch queue and flush.
// Optional same-cycle empty-queue bypass when IR_BYPASS_EN is defined.
module ir_queue
    import mips_ir_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     ir_we,
    output logic                     ir_full,
    input  logic                     ir_adv,
    input  logic                     ir_flush,
    output logic                     ir_valid,
    output logic [WIDTH-1:0]         data_out,
    output logic [OP_W-1:0]          opcode,
    output logic [REG_W-1:0]         rs,
    output logic [REG_W-1:0]         rt,
    output logic [REG_W-1:0]         rd,
    output logic [SHAMT_W-1:0]       shamt,
    output logic [FUNCT_W-1:0]       funct,
    output logic [IMM_W-1:0]         imm16,
    output logic [ADDR_W-1:0]        addr26,
    output logic [$clog2(DEPTH):0]   ir_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic empty;
    logic full;
    logic byp;
    logic byp_consume;
    logic push;
    logic pop;
    logic [WIDTH-1:0] head;
    logic [31:0]      dec_word;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

`ifdef IR_BYPASS_EN
    assign byp = empty & ir_we & ~ir_flush;
`else
    assign byp = 1'b0;
`endif

    // A bypassed word that is consumed at once never enters storage.
    assign byp_consume = byp & ir_adv;
    assign pop  = ir_adv & ~empty;
    assign push = ir_we & (~full | pop) & ~byp_consume;

    // Pointer and occupancy next state; flush wins over push/pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (ir_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register; reset beats every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents survive flush and reset.
    always_ff @(posedge clk) begin
        if (!rst && !ir_flush && push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // Head word: storage when non-empty, nop when empty.
    always_comb begin
        head = empty ? WIDTH'(NOP) : mem_q[rd_ptr_q];
`ifdef IR_BYPASS_EN
        if (byp) head = data_in;
`endif
    end

    assign data_out = head;
    assign ir_valid = ~empty | byp;
    assign ir_full  = full;
    assign ir_count = count_q;
    assign dec_word = 32'(head);

    ir_field_decode u_dec (
        .instr_i  (dec_word),
        .opcode_o (opcode),
        .rs_o     (rs),
        .rt_o     (rt),
        .rd_o     (rd),
        .shamt_o  (shamt),
        .funct_o  (funct),
        .imm16_o  (imm16),
        .addr26_o (addr26)
    );

endmodule

// File: tb/tb_ir_queue.sv
// Directed checks for ir_queue: reset, fill/drain, wrap, flush, decode.
// Bypass checks are compiled in when IR_BYPASS_EN is defined.
module tb_ir_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        ir_we, ir_adv, ir_flush;
    logic        ir_full, ir_valid;
    logic [31:0] data_out;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] addr26;
    logic [2:0]  ir_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ir_queue #(.WIDTH(32), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .ir_we    (ir_we),
        .ir_full  (ir_full),
        .ir_adv   (ir_adv),
        .ir_flush (ir_flush),
        .ir_valid (ir_valid),
        .data_out (data_out),
        .opcode   (opcode),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .shamt    (shamt),
        .funct    (funct),
        .imm16    (imm16),
        .addr26   (addr26),
        .ir_count (ir_count)
    );

    typedef struct {
        logic        we;
        logic        adv;
        logic        flush;
        logic [31:0] din;
        logic        ev;
        logic        ef;
        logic [2:0]  ec;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string name, input logic ev,
                             input logic ef, input logic [2:0] ec,
                             input logic [31:0] ed);
        chk({name, ".valid"}, 32'(ir_valid), 32'(ev));
        chk({name, ".full"},  32'(ir_full),  32'(ef));
        chk({name, ".count"}, 32'(ir_count), 32'(ec));
        chk({name, ".dout"},  data_out,      ed);
    endtask

    task automatic idle();
        ir_we    = 1'b0;
        ir_adv   = 1'b0;
        ir_flush = 1'b0;
        data_in  = 32'h0;
    endtask

    // Drive one cycle, then observe registered state with inputs idle.
    task automatic step(input logic we, input logic adv,
                        input logic fl, input logic [31:0] din);
        @(negedge clk);
        ir_we    = we;
        ir_adv   = adv;
        ir_flush = fl;
        data_in  = din;
        @(posedge clk);
        #1 idle();
        #1;
    endtask

    initial begin
        logic [31:0] mq[$];
        logic [31:0] w;

        tbl[0]  = '{1,0,0,32'h2008_0001, 1,0,3'd1,32'h2008_0001};
        tbl[1]  = '{1,0,0,32'h2008_0002, 1,0,3'd2,32'h2008_0001};
        tbl[2]  = '{1,0,0,32'h2008_0003, 1,0,3'd3,32'h2008_0001};
        tbl[3]  = '{1,0,0,32'h2008_0004, 1,1,3'd4,32'h2008_0001};
        tbl[4]  = '{1,0,0,32'h2008_0005, 1,1,3'd4,32'h2008_0001};
        tbl[5]  = '{0,1,0,32'h0,         1,0,3'd3,32'h2008_0002};
        tbl[6]  = '{0,1,0,32'h0,         1,0,3'd2,32'h2008_0003};
        tbl[7]  = '{0,1,0,32'h0,         1,0,3'd1,32'h2008_0004};
        tbl[8]  = '{0,1,0,32'h0,         0,0,3'd0,32'h0};
        tbl[9]  = '{0,1,0,32'h0,         0,0,3'd0,32'h0};
        tbl[10] = '{1,0,0,32'h0000_0010, 1,0,3'd1,32'h0000_0010};
        tbl[11] = '{1,0,0,32'h0000_0011, 1,0,3'd2,32'h0000_0010};
        tbl[12] = '{1,0,0,32'h0000_0012, 1,0,3'd3,32'h0000_0010};
        tbl[13] = '{1,0,0,32'h0000_0013, 1,1,3'd4,32'h0000_0010};
        tbl[14] = '{1,1,0,32'h0000_0020, 1,1,3'd4,32'h0000_0011};

        idle();
        rst     = 1'b1;
        ir_we   = 1'b1;
        data_in = 32'h2008_0005;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle();
        #1 chk_state("reset", 0, 0, 3'd0, 32'h0);
        chk("reset.opcode", 32'(opcode), 32'h0);

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].we, tbl[i].adv, tbl[i].flush, tbl[i].din);
            chk_state($sformatf("vec%0d", i),
                      tbl[i].ev, tbl[i].ef, tbl[i].ec, tbl[i].ed);
        end

        // Queue now holds 11,12,13,20; three laps of push+pop on full.
        mq = '{32'h11, 32'h12, 32'h13, 32'h20};
        for (int k = 0; k < 12; k++) begin
            w = 32'h21 + 32'(k);
            step(1, 1, 0, w);
            void'(mq.pop_front());
            mq.push_back(w);
            chk_state($sformatf("wrap%0d", k), 1, 1, 3'd4, mq[0]);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 0, 32'h0);
            void'(mq.pop_front());
            chk_state($sformatf("drain%0d", k), mq.size() != 0, 0,
                      3'(mq.size()), mq.size() != 0 ? mq[0] : 32'h0);
        end

        step(1, 0, 0, 32'h0000_0AA1);
        step(1, 0, 0, 32'h0000_0AA2);
        chk_state("pre_flush", 1, 0, 3'd2, 32'h0000_0AA1);
        step(1, 1, 1, 32'hDEAD_BEEF);
        chk_state("flush", 0, 0, 3'd0, 32'h0);

        step(1, 0, 0, 32'h0128_5020);
        chk_state("post_flush", 1, 0, 3'd1, 32'h0128_5020);
        chk("dec.opcode", 32'(opcode), 32'h0);
        chk("dec.rs",     32'(rs),     32'd9);
        chk("dec.rt",     32'(rt),     32'd8);
        chk("dec.rd",     32'(rd),     32'd10);
        chk("dec.shamt",  32'(shamt),  32'h0);
        chk("dec.funct",  32'(funct),  32'h20);
        chk("dec.imm16",  32'(imm16),  32'h5020);
        chk("dec.addr26", 32'(addr26), 32'h0128_5020);
        step(0, 1, 0, 32'h0);
        chk_state("post_flush_pop", 0, 0, 3'd0, 32'h0);

        step(1, 0, 0, 32'h8C43_0004);
        step(1, 0, 0, 32'h8C43_0008);
        @(negedge clk);
        rst      = 1'b1;
        ir_we    = 1'b1;
        ir_adv   = 1'b1;
        ir_flush = 1'b1;
        data_in  = 32'h1234_5678;
        @(posedge clk);
        #1 rst = 1'b0;
        idle();
        #1 chk_state("mid_reset", 0, 0, 3'd0, 32'h0);

`ifdef IR_BYPASS_EN
        @(negedge clk);
        ir_we   = 1'b1;
        data_in = 32'h8C43_0004;
        #1 chk("byp.dout", data_out, 32'h8C43_0004);
        chk("byp.valid", 32'(ir_valid), 32'h1);
        ir_adv = 1'b1;
        @(posedge clk);
        #1 idle();
        #1 chk_state("byp_consume", 0, 0, 3'd0, 32'h0);
        step(1, 0, 0, 32'h8C43_0004);
        chk_state("byp_store", 1, 0, 3'd1, 32'h8C43_0004);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
